// File: rtl/skin_ctrl_pkg.sv
// skin_ctrl_pkg: shared frame FSM encoding, error codes and default sync/timeout constants
package skin_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SYNC    = 3'd1;
  localparam state_t ST_LEN_H   = 3'd2;
  localparam state_t ST_LEN_L   = 3'd3;
  localparam state_t ST_PAYLOAD = 3'd4;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [7:0] DEF_SYNC0 = 8'h55;
  localparam logic [7:0] DEF_SYNC1 = 8'hAA;
  localparam logic [15:0] DEF_TIMEOUT = 16'd43400;
endpackage

// File: rtl/skin_byte_timer.sv
// skin_byte_timer: inter-byte idle timer, expire pulses once LIMIT-1 silent cycles follow a kick
// ports: clk/rst clock and sync reset; run_i keep counting (else cleared); kick_i byte seen;
//   expire_o idle limit reached this cycle with no kick
module skin_byte_timer #(
  parameter int W = 16,
  parameter logic [W-1:0] LIMIT = W'(43400)
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // the kick cycle itself counts as zero, so the following cycle already reads 1
  always_comb cnt_d = !run_i ? '0 : kick_i ? W'(1) : cnt_q + W'(1);
  assign expire_o = !kick_i && cnt_q == LIMIT - W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/skin_frame_ctrl.sv
// skin_frame_ctrl: sync/length frame sequencer gating 3*N payload bytes from uart_rx into the RGB assembler
// ports: sys_clk/sys_rst clock and sync active-high reset; rx_vld/rx_data received byte strobe;
//   pix_vld/pix_data registered payload byte; pipe_clr assembler byte-phase clear at frame start;
//   frame_busy/frame_done/frame_err/err_code frame status; pix_cnt pixels forwarded this frame
module skin_frame_ctrl
  import skin_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC0       = DEF_SYNC0,
  parameter logic [7:0]  SYNC1       = DEF_SYNC1,
  parameter logic [15:0] TIMEOUT_CYC = DEF_TIMEOUT,
  parameter int          CNT_W       = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rx_vld,
  input  logic [7:0]       rx_data,
  output logic             pix_vld,
  output logic [7:0]       pix_data,
  output logic             pipe_clr,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pix_cnt
);
  state_t           state_q, state_d;
  logic [7:0]       len_h_q, len_h_d, data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [1:0]       phase_q, phase_d, code_q, code_d;
  logic             vld_q, vld_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             expire;
  logic [15:0]      len_rx;
  assign len_rx  = {len_h_q, rx_data};
  assign cnt_inc = cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    len_h_d = len_h_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    code_d  = code_q;
    data_d  = data_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (rx_vld) begin
      case (state_q)
        ST_IDLE:  state_d = rx_data == SYNC0 ? ST_SYNC : ST_IDLE;
        ST_SYNC:  state_d = rx_data == SYNC1 ? ST_LEN_H : rx_data == SYNC0 ? ST_SYNC : ST_IDLE;
        ST_LEN_H: begin
          len_h_d = rx_data;
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          if (len_rx == 16'd0) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN0;
            state_d = ST_IDLE;
          end else begin
            len_d   = CNT_W'(len_rx);
            cnt_d   = '0;
            phase_d = 2'd0;
            clr_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          vld_d   = 1'b1;
          data_d  = rx_data;
          phase_d = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
          // a pixel is complete on its third byte; the last pixel closes the frame
          if (phase_q == 2'd2) begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire && state_q != ST_IDLE) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      len_h_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      code_q  <= ERR_NONE;
      data_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_h_q <= len_h_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      code_q  <= code_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // run follows the next state so the byte that leaves IDLE already starts the count
  skin_byte_timer #(.W(16), .LIMIT(TIMEOUT_CYC)) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .run_i    (state_d != ST_IDLE),
    .kick_i   (rx_vld),
    .expire_o (expire)
  );
  assign pix_vld    = vld_q;
  assign pix_data   = data_q;
  assign pipe_clr   = clr_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = code_q;
  assign pix_cnt    = cnt_q;
endmodule

// File: tb/tb_skin_frame_ctrl.sv
// tb_skin_frame_ctrl: vector table, directed corner sequences and randomized streams against a byte-level model
module tb_skin_frame_ctrl;
  localparam int TO = 200;
  logic clk = 1'b0, rst = 1'b1, rx_vld = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic pix_vld, pipe_clr, frame_busy, frame_done, frame_err;
  logic [7:0] pix_data;
  logic [1:0] err_code;
  logic [15:0] pix_cnt;
  logic [30:0] dut_o;
  int nvec = 0, nbad = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  skin_frame_ctrl #(.TIMEOUT_CYC(16'(TO))) dut (
    .sys_clk(clk), .sys_rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .pix_vld(pix_vld), .pix_data(pix_data), .pipe_clr(pipe_clr), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .pix_cnt(pix_cnt)
  );
  assign dut_o = {pix_vld, pix_data, pipe_clr, frame_busy, frame_done, frame_err, err_code, pix_cnt};
  bit [7:0] hdr[$];
  int len = 0, got = 0, idle = 0;
  bit in_pay = 1'b0;
  bit m_vld, m_clr, m_busy, m_done, m_err;
  bit [7:0] m_data;
  bit [1:0] m_code;
  bit [15:0] m_cnt;
  task automatic model_step();
    if (rst) begin
      hdr.delete(); in_pay = 0; got = 0; idle = 0;
      {m_vld, m_data, m_clr, m_busy, m_done, m_err, m_code, m_cnt} = '0;
    end else begin
      {m_vld, m_clr, m_done, m_err} = '0;
      if (rx_vld) begin
        idle = 0;
        if (in_pay) begin
          m_vld = 1; m_data = rx_data; got++; m_cnt = 16'(got / 3);
          if (got == 3 * len) begin in_pay = 0; m_done = 1; m_busy = 0; end
        end else case (hdr.size())
          0: if (rx_data == 8'h55) hdr.push_back(rx_data);
          1: if (rx_data == 8'hAA) hdr.push_back(rx_data); else if (rx_data != 8'h55) hdr.delete();
          2: hdr.push_back(rx_data);
          default: begin
            len = int'(hdr[2]) * 256 + int'(rx_data);
            hdr.delete();
            if (len == 0) begin m_err = 1; m_code = 2'd1; end
            else begin in_pay = 1; got = 0; m_clr = 1; m_busy = 1; m_cnt = 0; end
          end
        endcase
      end else if (in_pay || hdr.size() > 0) begin
        idle++;
        if (idle == TO - 1) begin m_err = 1; m_code = 2'd2; m_busy = 0; in_pay = 0; hdr.delete(); end
      end
    end
  endtask
  always @(posedge clk) model_step();
  always @(negedge clk) if (chk_en) begin
    nvec++;
    if (dut_o !== {m_vld, m_data, m_clr, m_busy, m_done, m_err, m_code, m_cnt}) begin
      nbad++;
      $display("FAIL model @%0t: dut %h expected %h", $time, dut_o,
               {m_vld, m_data, m_clr, m_busy, m_done, m_err, m_code, m_cnt});
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input bit v, input bit [7:0] d);
    rx_vld = v;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input int n, input string nm);
    int nv = 0, nd = 0;
    bit ok = 1;
    step(1, 8'h55); step(1, 8'hAA); step(1, 8'(n >> 8)); step(1, 8'(n));
    chk({nm, "_clr"}, {pipe_clr, pix_vld, frame_busy}, 3'b101);
    for (int i = 0; i < 3 * n; i++) begin
      step(1, 8'(i * 7 + 3));
      if (pix_vld) nv++;
      if (!pix_vld || pix_data !== 8'(i * 7 + 3)) ok = 0;
      if (frame_done) nd++;
    end
    chk({nm, "_nvld"}, nv, 3 * n);
    chk({nm, "_data"}, ok, 1);
    chk({nm, "_end"}, {nd[1:0], frame_done, frame_busy, pix_cnt}, {2'd1, 1'b1, 1'b0, 16'(n)});
    step(0, 8'h00);
    chk({nm, "_after"}, {frame_done, frame_busy, pix_vld}, 3'b000);
  endtask
  typedef struct { bit v; bit [7:0] d; logic [30:0] e; } vec_t;
  function automatic vec_t mk(bit v, bit [7:0] d, bit vl, bit [7:0] pd, bit c, bit b, bit dn,
                              bit er, bit [1:0] cd, bit [15:0] n);
    return '{v, d, {vl, pd, c, b, dn, er, cd, n}};
  endfunction
  vec_t tbl[$];
  bit [7:0] bs[$];
  int n, nl, g;
  initial begin
    tbl.push_back(mk(1, 8'h55, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 8'h00, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h10, 1, 8'h10, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h20, 1, 8'h20, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h30, 1, 8'h30, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h40, 1, 8'h40, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h50, 1, 8'h50, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h60, 1, 8'h60, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 8'h00, 0, 8'h60, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h55, 0, 8'h60, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h55, 0, 8'h60, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'hAA, 0, 8'h60, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h00, 0, 8'h60, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h01, 0, 8'h60, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h11, 1, 8'h11, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h22, 1, 8'h22, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 8'h33, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h33, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 8'h33, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'hAA, 0, 8'h33, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 8'h33, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 8'h33, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 8'h33, 0, 0, 0, 0, 1, 1));
    step(0, 8'h00); step(0, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset", dut_o, 0);
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), dut_o, tbl[i].e);
    end
    step(1, 8'h55); step(1, 8'hAA); step(1, 8'h00); step(1, 8'h01); step(1, 8'h11); step(1, 8'h22);
    n = 1;
    while (!frame_err && n < TO + 20) begin step(0, 8'h00); n++; end
    chk("timeout_cycles", n, TO);
    chk("timeout_status", {frame_err, frame_busy, err_code, pix_cnt}, {1'b1, 1'b0, 2'b10, 16'd0});
    frame(1, "after_to");
    step(1, 8'h55);
    repeat (TO - 2) step(0, 8'h00);
    step(1, 8'hAA);
    chk("race_no_err", frame_err, 0);
    step(1, 8'h00); step(1, 8'h01); step(1, 8'h01); step(1, 8'h02); step(1, 8'h03);
    chk("race_done", {frame_done, pix_cnt}, {1'b1, 16'd1});
    step(1, 8'h55); step(1, 8'hAA); step(1, 8'h00); step(1, 8'h02);
    step(1, 8'h10); step(1, 8'h20); step(1, 8'h30); step(1, 8'h40);
    rst = 1'b1;
    step(0, 8'h00);
    rst = 1'b0;
    chk("rst_outputs", dut_o, 0);
    repeat (3) begin step(0, 8'h00); chk("rst_no_err", frame_err, 0); end
    frame(2, "post_rst");
    step(1, 8'h00); chk("garbage0", {pix_vld, pipe_clr, frame_busy, frame_done, frame_err}, 0);
    step(1, 8'hFF); chk("garbage1", {pix_vld, pipe_clr, frame_busy, frame_done, frame_err}, 0);
    step(1, 8'hAA); chk("garbage2", {pix_vld, pipe_clr, frame_busy, frame_done, frame_err}, 0);
    step(1, 8'h12); chk("garbage3", {pix_vld, pipe_clr, frame_busy, frame_done, frame_err}, 0);
    frame(300, "big");
    for (int f = 0; f < 60; f++) begin
      bs.delete();
      nl = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) bs.push_back(8'($urandom));
      bs.push_back(8'h55);
      if ($urandom_range(0, 3) == 0) bs.push_back(8'h55);
      bs.push_back($urandom_range(0, 7) == 0 ? 8'($urandom) : 8'hAA);
      bs.push_back(8'h00);
      bs.push_back(8'(nl));
      for (int i = 0; i < 3 * nl; i++) bs.push_back(8'($urandom));
      foreach (bs[i]) begin
        g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 3, TO + 1)) : int'($urandom_range(0, 2));
        repeat (g) step(0, 8'($urandom));
        if ($urandom_range(0, 199) == 0) begin rst = 1'b1; step(0, 8'h00); rst = 1'b0; end
        step(1, bs[i]);
      end
    end
    repeat (TO + 2) step(0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
